// File: rtl/gray2bin_serial_pkg.sv
// Shared definitions for the serial Gray-to-binary decoder: FSM state encoding
// and the default word width.
package gray2bin_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/gray2bin_serial_adj_check.sv
// Combinational Gray adjacency test: one_step is high when a and b differ in
// exactly one bit position.
module gray_adj_check
    import gray2bin_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             one_step
);

    logic [WIDTH-1:0] diff;
    int               ones;

    always_comb begin
        diff = a ^ b;
        ones = 0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + int'(diff[i]);
        end
        one_step = (ones == 1);
    end

endmodule

// File: rtl/gray2bin_serial.sv
// Serial Gray-to-binary decoder: resolves one bit per clock from MSB to LSB,
// with valid/ready on both sides and a Gray-stream adjacency monitor.
module gray2bin_serial
    import gray2bin_serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit CHECK_ADJ = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic             out_adj_err,
    output logic             busy
);

    // A single-bit word still needs a legal (1-bit) index register.
    localparam int              IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_START = IDX_W'((WIDTH > 1) ? WIDTH - 2 : 0);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
    logic             prev_valid_q, prev_valid_d;
    logic             adj_err_q, adj_err_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             out_valid_q, out_valid_d;
    logic             one_step;
    logic [WIDTH-1:0] step_bits;

    gray_adj_check #(.WIDTH(WIDTH)) u_adj (
        .a        (in_gray),
        .b        (prev_gray_q),
        .one_step (one_step)
    );

    // Candidate value of every bit for the cycle in which it gets resolved.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_step
        if (gi == WIDTH - 1) begin : g_msb
            assign step_bits[gi] = g_q[gi];
        end else begin : g_low
            assign step_bits[gi] = b_q[gi+1] ^ g_q[gi];
        end
    end

    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        b_d          = b_q;
        idx_d        = idx_q;
        prev_gray_d  = prev_gray_q;
        prev_valid_d = prev_valid_q;
        adj_err_d    = adj_err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    g_d            = in_gray;
                    b_d            = '0;
                    b_d[WIDTH-1]   = in_gray[WIDTH-1];
                    idx_d          = IDX_START;
                    adj_err_d      = CHECK_ADJ && prev_valid_q && !one_step;
                    prev_gray_d    = in_gray;
                    prev_valid_d   = 1'b1;
                    state_d        = (WIDTH == 1) ? ST_DONE : ST_CONV;
                end
            end
            ST_CONV: begin
                b_d[idx_q] = step_bits[idx_q];
                if (idx_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        busy_d      = (state_d == ST_CONV);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            g_q          <= '0;
            b_q          <= '0;
            idx_q        <= '0;
            prev_gray_q  <= '0;
            prev_valid_q <= 1'b0;
            adj_err_q    <= 1'b0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            b_q          <= b_d;
            idx_q        <= idx_d;
            prev_gray_q  <= prev_gray_d;
            prev_valid_q <= prev_valid_d;
            adj_err_q    <= adj_err_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign out_valid   = out_valid_q;
    assign out_bin     = b_q;
    assign out_adj_err = adj_err_q;

endmodule

// File: tb/tb_gray2bin_serial.sv
// Scoreboard bench for gray2bin_serial: a 4-bit checked instance plus a 1-bit
// instance with the adjacency check disabled.
module tb_gray2bin_serial;

    typedef struct {
        logic [3:0] bin;
        logic       adj;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_gray = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_bin;
    logic       out_adj_err;
    logic       busy;

    logic       v1_in_valid = 1'b0;
    logic       v1_in_ready;
    logic [0:0] v1_in_gray = 1'b0;
    logic       v1_out_valid;
    logic       v1_out_ready = 1'b0;
    logic [0:0] v1_out_bin;
    logic       v1_out_adj_err;
    logic       v1_busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc = 0;
    logic prev_ov = 1'b0;
    exp_t sbq[$];

    logic [3:0] m_prev = 4'd0;
    logic       m_prev_valid = 1'b0;

    gray2bin_serial #(.WIDTH(4), .CHECK_ADJ(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_gray(in_gray), .out_valid(out_valid), .out_ready(out_ready),
        .out_bin(out_bin), .out_adj_err(out_adj_err), .busy(busy)
    );

    gray2bin_serial #(.WIDTH(1), .CHECK_ADJ(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1_in_valid), .in_ready(v1_in_ready),
        .in_gray(v1_in_gray), .out_valid(v1_out_valid), .out_ready(v1_out_ready),
        .out_bin(v1_out_bin), .out_adj_err(v1_out_adj_err), .busy(v1_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    // Output monitor: latency of each result and scoreboard comparison.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) last_acc = cyc;
            if (out_valid && !prev_ov) chk("latency", cyc - last_acc, 4);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%0d required=none", out_bin);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("out_bin", out_bin, e.bin);
                    chk("out_adj_err", out_adj_err, e.adj);
                    $display("result bin=%b adj=%b exp_bin=%b exp_adj=%b", out_bin, out_adj_err, e.bin, e.adj);
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic do_reset();
        @(posedge clk) #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        m_prev = 4'd0;
        m_prev_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_bin", out_bin, 0);
        chk("rst_out_adj_err", out_adj_err, 0);
        @(posedge clk) #2;
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [3:0] g, input logic [3:0] eb, input logic ea, input bit push);
        int n;
        @(posedge clk) #2;
        in_valid = 1'b1;
        in_gray  = g;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout actual=0 required=1");
                break;
            end
        end
        if (push) sbq.push_back('{bin: eb, adj: ea});
        $display("send gray=%b exp_bin=%b exp_adj=%b", g, eb, ea);
        @(posedge clk) #2;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", sbq.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    logic [3:0] gray_seq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_v1_out_valid", v1_out_valid, 0);
        chk("rst_v1_in_ready", v1_in_ready, 1);

        // Full Gray sequence, then the legal wrap back to zero.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(gray_seq[i], 4'(i), 1'b0, 1'b1);
        send(4'b0000, 4'b0000, 1'b0, 1'b1);
        drain();

        // Backpressure: result held while the consumer stalls.
        do_reset();
        out_ready = 1'b0;
        send(4'b0110, 4'b0100, 1'b0, 1'b1);
        for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold_out_valid_%0d", i), out_valid, 1);
            chk($sformatf("hold_out_bin_%0d", i), out_bin, 4'b0100);
            chk($sformatf("hold_in_ready_%0d", i), in_ready, 0);
            @(posedge clk) #2;
            if (i < 4) begin
                in_valid = 1'b1;
                in_gray  = 4'b1111;
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        @(negedge clk);
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);
        drain();

        // Adjacency errors: multi-bit jump, repeat, then a legal step.
        do_reset();
        send(4'b0000, 4'b0000, 1'b0, 1'b1);
        send(4'b0011, 4'b0010, 1'b1, 1'b1);
        send(4'b0011, 4'b0010, 1'b1, 1'b1);
        send(4'b0010, 4'b0011, 1'b0, 1'b1);
        drain();

        // Reset in the middle of a conversion discards it and clears history.
        do_reset();
        send(4'b1111, 4'b1010, 1'b0, 1'b0);
        @(posedge clk) #2;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midconv_busy", busy, 1);
        @(negedge clk);
        chk("midconv_rst_out_valid", out_valid, 0);
        chk("midconv_rst_in_ready", in_ready, 1);
        chk("midconv_rst_busy", busy, 0);
        @(posedge clk) #2;
        rst_n = 1'b1;
        send(4'b0101, 4'b0110, 1'b0, 1'b1);
        drain();

        // Single-bit instance with the adjacency check disabled.
        for (int k = 0; k < 2; k++) begin
            @(posedge clk) #2;
            v1_in_valid = 1'b1;
            v1_in_gray  = 1'b1;
            for (int n = 0; n < 100; n++) begin
                @(negedge clk);
                if (v1_in_ready) break;
            end
            @(posedge clk) #2;
            v1_in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("w1_out_valid_%0d", k), v1_out_valid, 1);
            chk($sformatf("w1_out_bin_%0d", k), v1_out_bin, 1);
            chk($sformatf("w1_out_adj_err_%0d", k), v1_out_adj_err, 0);
            $display("w1 word %0d bin=%b adj=%b", k, v1_out_bin, v1_out_adj_err);
            @(posedge clk) #2;
            v1_out_ready = 1'b1;
            @(posedge clk) #2;
            v1_out_ready = 1'b0;
        end

        // Source drives a new word every cycle; only words seen with in_ready count.
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk) #2;
            in_valid = 1'b1;
            in_gray  = 4'((k * 5 + 3) ^ (k >> 2));
            @(negedge clk);
            if (in_ready) begin
                logic ea;
                ea = m_prev_valid && ($countones(in_gray ^ m_prev) != 1);
                sbq.push_back('{bin: g2b(in_gray), adj: ea});
                $display("stream gray=%b exp_bin=%b exp_adj=%b", in_gray, g2b(in_gray), ea);
                m_prev = in_gray;
                m_prev_valid = 1'b1;
            end
        end
        @(posedge clk) #2;
        in_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
